// File: rtl/channel_acq_sequencer.sv
// Acquisition sequencer for one analog channel: programs the DAC offset,
// waits for settling, discards warm-up samples and captures a burst.
// Ports: clk/reset; i_Start, i_Abort commands; i_Cfg* burst config;
//   i_AdcSample input; o_DacOffset, o_AnalogEnable to the analog top;
//   o_Sample/o_SampleValid stream; o_Busy, o_Done status;
//   o_Max, o_AboveCount per-burst statistics.
module channel_acq_sequencer #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int ADC_LATENCY    = 1,
  parameter int WARMUP_SAMPLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_Start,
  input  logic       i_Abort,
  input  logic [7:0] i_CfgOffset,
  input  logic [7:0] i_CfgBurstLen,
  input  logic [7:0] i_CfgThreshold,
  input  logic [7:0] i_AdcSample,
  output logic [7:0] o_DacOffset,
  output logic       o_AnalogEnable,
  output logic [7:0] o_Sample,
  output logic       o_SampleValid,
  output logic       o_Busy,
  output logic       o_Done,
  output logic [7:0] o_Max,
  output logic [8:0] o_AboveCount
);

  localparam int DISC = ADC_LATENCY + WARMUP_SAMPLES;
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] DISC_LAST = 8'(DISC - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    DISCARD,
    CAPTURE,
    DONE
  } state_t;

  state_t     state;
  logic [7:0] cnt;
  logic [8:0] cap_cnt;
  logic [8:0] burst_len;
  logic [7:0] thresh;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      cap_cnt        <= '0;
      burst_len      <= '0;
      thresh         <= '0;
      o_DacOffset    <= '0;
      o_AnalogEnable <= 1'b0;
      o_Sample       <= '0;
      o_SampleValid  <= 1'b0;
      o_Busy         <= 1'b0;
      o_Done         <= 1'b0;
      o_Max          <= '0;
      o_AboveCount   <= '0;
    end else begin
      o_SampleValid <= 1'b0;
      o_Done        <= 1'b0;
      if (i_Abort && state != IDLE) begin
        state          <= IDLE;
        o_AnalogEnable <= 1'b0;
        o_Busy         <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (i_Start && !i_Abort) begin
              // A zero length maps to 256 via the ninth bit.
              burst_len    <= {(i_CfgBurstLen == 8'd0), i_CfgBurstLen};
              thresh       <= i_CfgThreshold;
              o_DacOffset  <= i_CfgOffset;
              o_Max        <= '0;
              o_AboveCount <= '0;
              cnt          <= '0;
              cap_cnt      <= '0;
              o_Busy       <= 1'b1;
              state        <= SETTLE;
            end
          end
          SETTLE: begin
            if (cnt == SETTLE_LAST) begin
              cnt            <= '0;
              o_AnalogEnable <= 1'b1;
              state          <= (DISC == 0) ? CAPTURE : DISCARD;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          DISCARD: begin
            if (cnt == DISC_LAST) begin
              cnt   <= '0;
              state <= CAPTURE;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          CAPTURE: begin
            o_Sample      <= i_AdcSample;
            o_SampleValid <= 1'b1;
            if (i_AdcSample > o_Max) o_Max <= i_AdcSample;
            if (i_AdcSample > thresh) begin
              o_AboveCount <= o_AboveCount + 9'd1;
            end
            if (cap_cnt == burst_len - 9'd1) begin
              o_AnalogEnable <= 1'b0;
              state          <= DONE;
            end else begin
              cap_cnt <= cap_cnt + 9'd1;
            end
          end
          DONE: begin
            o_Done <= 1'b1;
            o_Busy <= 1'b0;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/channel_acq_sequencer.md
# channel_acq_sequencer

Acquisition sequencer for one analog channel. It programs the channel DAC offset, waits for the analog front end to settle, and enables the ADC. It then discards warm-up samples, captures a burst of N ADC samples, and reports per-burst statistics: the maximum sample and the count of samples above a threshold. It sits between the channel register/command logic and the channel analog top, and drives that block's DAC offset and analog-enable inputs.

## Interface
Parameters:
- SETTLE_CYCLES, 16: cycles between DAC update and analog enable; legal range 1..255.
- ADC_LATENCY, 1: cycles from analog enable to the first meaningful ADC output; legal range 0..7.
- WARMUP_SAMPLES, 2: additional valid samples discarded after ADC_LATENCY; legal range 0..15.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_Start  in  1  one-cycle command pulse; honoured only in IDLE.
- i_Abort  in  1  level; terminates any acquisition.
- i_CfgOffset  in  8  DAC offset for the burst; latched on accepted start.
- i_CfgBurstLen  in  8  number of captured samples; 0 means 256; latched on accepted start.
- i_CfgThreshold  in  8  unsigned threshold; latched on accepted start.
- i_AdcSample  in  8  ADC output from the analog channel.
- o_DacOffset  out  8  to the channel DAC input.
- o_AnalogEnable  out  1  to the channel analog enable.
- o_Sample  out  8  captured sample.
- o_SampleValid  out  1  one-cycle strobe per captured sample.
- o_Busy  out  1  high from the accepted start until DONE or abort.
- o_Done  out  1  one-cycle pulse on burst completion.
- o_Max  out  8  maximum captured sample of the last burst.
- o_AboveCount  out  9  number of captured samples strictly greater than the threshold.

## Operation
- States: IDLE, SETTLE, DISCARD, CAPTURE, DONE.
- IDLE:
  - i_Start=1 and i_Abort=0 → latch config, load o_DacOffset=i_CfgOffset, clear o_Max, o_AboveCount and the counters, set o_Busy → SETTLE.
- SETTLE:
  - o_AnalogEnable=0; count SETTLE_CYCLES edges.
  - On the last edge, set o_AnalogEnable=1 → DISCARD.
  - If ADC_LATENCY+WARMUP_SAMPLES=0, go directly to CAPTURE.
- DISCARD:
  - Ignore i_AdcSample for ADC_LATENCY+WARMUP_SAMPLES edges → CAPTURE.
- CAPTURE:
  - Each edge, register i_AdcSample to o_Sample and pulse o_SampleValid.
  - If sample > o_Max, update o_Max.
  - If sample > threshold (unsigned, strict), increment o_AboveCount.
  - After N captures, o_AnalogEnable=0 → DONE.
- DONE:
  - o_Done=1 for one cycle, o_Busy=0 → IDLE.
- Statistics hold their values until the next accepted start.
- o_DacOffset holds its last programmed value in all states, including after abort.
- i_Abort in any non-IDLE state:
  - Next edge: IDLE, o_AnalogEnable=0, o_Busy=0.
  - No o_Done; no o_SampleValid on that edge.
  - Statistics retain their partial values.
- i_Abort has priority over i_Start in the same cycle.
- i_Start while busy is ignored and is not queued.
- Config inputs changed mid-burst have no effect.
- Counters: burst counter 9 bits (0 maps to 256). The o_AboveCount maximum is 256, with no wrap.
- Reset (asynchronous, any time, including mid-burst): state IDLE; every output is 0 (o_DacOffset=0, o_AnalogEnable=0, o_Sample=0, o_SampleValid=0, o_Busy=0, o_Done=0, o_Max=0, o_AboveCount=0).

## Timing
- Edge E0 samples the accepted start. o_Busy and o_DacOffset update after E0.
- o_AnalogEnable rises after edge E0+SETTLE_CYCLES.
- Discard edges: E0+SETTLE_CYCLES+1 through E0+SETTLE_CYCLES+ADC_LATENCY+WARMUP_SAMPLES.
- Capture k (k=1..N) is at edge Ec(k) = E0+SETTLE_CYCLES+ADC_LATENCY+WARMUP_SAMPLES+k. o_Sample/o_SampleValid are valid after that edge.
- After Ec(N): o_AnalogEnable=0, the final o_SampleValid is high, and the statistics are final.
- After Ec(N)+1: o_Done=1, o_Busy=0.
- Back-to-back operation: a start sampled in the cycle o_Done is high is accepted, because the FSM is then in IDLE.

## Test plan
- Reset mid-CAPTURE: assert reset → all outputs 0 immediately; no o_Done; the next start runs a full, normal burst.
- Nominal burst (SETTLE=4, LAT=1, WARMUP=2, offset 0x80, N=4, threshold 0x10, ADC ramps 1 per cycle from 0x0E at edge 5):
  - Enable rises after edge 4.
  - Edges 5–7 are discarded.
  - Samples 0x11, 0x12, 0x13, 0x14 are captured at edges 8–11.
  - o_Done after edge 12, with o_Max=0x14 and o_AboveCount=4.
- i_CfgBurstLen=0 with constant ADC 0xFF, threshold 0xFE → exactly 256 o_SampleValid strobes, o_AboveCount=256, o_Max=0xFF.
- Threshold equality (threshold 0x40, samples 0x40, 0x41, 0x3F) → o_AboveCount=1, o_Max=0x41.
- Abort during SETTLE, then abort during CAPTURE after 2 samples:
  - Both: enable low and busy low on the next edge; no o_Done.
  - After the second: o_AboveCount reflects the 2 captured samples; o_DacOffset is retained.
- Start while busy, start and abort together in IDLE, and start on the o_Done cycle → ignored, ignored, and accepted respectively.
